// File: rtl/add_chunk.sv
// add_chunk: combinational W-bit adder slice, time-multiplexed by adder_chunked.
// Ports: a, b, ci in; sum, co out; c_msb is the carry into the top sum bit.
module add_chunk #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] sum,
   output logic         co,
   output logic         c_msb
);

   logic [W:0] full;

   assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   assign sum   = full[W-1:0];
   assign co    = full[W];
   // top sum bit is a ^ b ^ cin, so the MSB carry-in falls out directly
   assign c_msb = full[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/adder_chunked.sv
// adder_chunked: WIDTH-bit add/sub, CHUNK bits per clock, carry kept in a reg.
// Ports: clk, reset, in_valid/in_ready + a, b, ci, sub in; out_valid/out_ready + result, carry, overflow out.
module adder_chunked #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   generate
      if (CHUNK <= 0 || WIDTH <= 0 || (WIDTH % CHUNK) != 0) begin : g_cfg_err
         $error("adder_chunked: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cy_q, cy_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic             rdy_q, rdy_d;

   int               idx;
   logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
   logic             ch_co, ch_cmsb;
   logic             ovf_rule;

   assign idx  = int'(cnt_q) * CHUNK;
   assign ch_a = a_q[idx +: CHUNK];
   assign ch_b = b_q[idx +: CHUNK];

   add_chunk #(
      .W(CHUNK)
   ) u_add (
      .a    (ch_a),
      .b    (ch_b),
      .ci   (cy_q),
      .sum  (ch_sum),
      .co   (ch_co),
      .c_msb(ch_cmsb)
   );

   // only meaningful on the last chunk, where ch_a/ch_b hold the operand MSBs
   assign ovf_rule = (a_q[WIDTH-1] == b_q[WIDTH-1])
                   & (ch_sum[CHUNK-1] != a_q[WIDTH-1]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      cy_d    = cy_q;
      res_d   = res_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && rdy_q) begin
               a_d     = a;
               // subtraction is a + ~b + 1
               b_d     = sub ? ~b : b;
               cy_d    = sub | ci;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            res_d[idx +: CHUNK] = ch_sum;
            cy_d = ch_co;
            if (cnt_q == LAST) begin
               co_d    = ch_co;
               ovf_d   = ovf_rule;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      rdy_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cy_q    <= 1'b0;
         res_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cy_q    <= cy_d;
         res_q   <= res_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         rdy_q   <= rdy_d;
      end
   end

   // MSB carry-in vs carry-out must agree with the sign-based overflow rule
   a_ovf_xcheck: assert property (
      @(posedge clk) disable iff (reset)
      (state_q == S_RUN && cnt_q == LAST) |-> (ovf_rule == (ch_co ^ ch_cmsb))
   );

   assign in_ready  = rdy_q;
   assign out_valid = (state_q == S_DONE);
   assign result    = res_q;
   assign carry     = co_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_chunked.sv
// tb_adder_chunked: directed + random checks of adder_chunked.
// Instances: 32/8, 4/1 and 8/8 configurations on one clock and reset.
`timescale 1ns/1ps
module tb_adder_chunked;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   logic        iv, ir, ici, isub, ov, ordy, co, ovf;
   logic [31:0] ia, ib, res;

   logic       iv4, ir4, ci4, sub4, ov4, ordy4, co4, ovf4;
   logic [3:0] a4, b4, res4;

   logic       iv8, ir8, ci8, sub8, ov8, ordy8, co8, ovf8;
   logic [7:0] a8, b8, res8;

   adder_chunked #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(iv), .in_ready(ir),
      .a(ia), .b(ib), .ci(ici), .sub(isub),
      .out_valid(ov), .out_ready(ordy),
      .result(res), .carry(co), .overflow(ovf)
   );

   adder_chunked #(.WIDTH(4), .CHUNK(1)) dut4 (
      .clk(clk), .reset(reset),
      .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .ci(ci4), .sub(sub4),
      .out_valid(ov4), .out_ready(ordy4),
      .result(res4), .carry(co4), .overflow(ovf4)
   );

   adder_chunked #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .ci(ci8), .sub(sub8),
      .out_valid(ov8), .out_ready(ordy8),
      .result(res8), .carry(co8), .overflow(ovf8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op32(input logic [31:0] x, input logic [31:0] y,
                       input logic c, input logic s,
                       output logic [31:0] r, output logic cr,
                       output logic of, output int lat);
      int n;
      n = 0;
      while (!ir && n < 50) begin
         tick();
         n++;
      end
      ia = x; ib = y; ici = c; isub = s; iv = 1'b1;
      tick();
      iv = 1'b0;
      lat = 0;
      while (!ov && lat < 50) begin
         tick();
         lat++;
      end
      r = res; cr = co; of = ovf;
      ordy = 1'b1;
      tick();
      ordy = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_chk++;
      if ({ir, ov, co, ovf, res} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h want=0", {ir, ov, co, ovf, res});
      end
      reset = 1'b0;
      n_chk++;
      if (ir !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_before_edge got=%b want=0", ir);
      end
      tick();
      n_chk++;
      if ({ir, ir4, ir8} !== 3'b111) begin
         n_fail++;
         $display("FAIL ready_after_release got=%b want=111", {ir, ir4, ir8});
      end
   endtask

   task automatic test_add_wrap();
      logic [31:0] r;
      logic cr, of;
      int lat;
      op32(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, r, cr, of, lat);
      n_chk++;
      if (r !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_result got=%h want=00000000", r);
      end
      n_chk++;
      if (cr !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_carry got=%b want=1", cr);
      end
      n_chk++;
      if (of !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_ovf got=%b want=0", of);
      end
      n_chk++;
      if (lat != 4) begin
         n_fail++;
         $display("FAIL wrap_latency got=%0d want=4", lat);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] r;
      logic cr, of;
      int lat;
      op32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, r, cr, of, lat);
      n_chk++;
      if ({of, cr, r} !== {1'b1, 1'b0, 32'h8000_0000}) begin
         n_fail++;
         $display("FAIL add_ovf got=%b%b_%h want=10_80000000", of, cr, r);
      end
      op32(32'h8000_0000, 32'h1, 1'b1, 1'b1, r, cr, of, lat);
      n_chk++;
      if ({of, cr, r} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin
         n_fail++;
         $display("FAIL sub_ovf got=%b%b_%h want=11_7fffffff", of, cr, r);
      end
      op32(32'h5, 32'h7, 1'b0, 1'b1, r, cr, of, lat);
      n_chk++;
      if ({of, cr, r} !== {1'b0, 1'b0, 32'hFFFF_FFFE}) begin
         n_fail++;
         $display("FAIL sub_borrow got=%b%b_%h want=00_fffffffe", of, cr, r);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] r;
      logic cr, of;
      int lat, n;
      n = 0;
      while (!ir && n < 50) begin
         tick();
         n++;
      end
      ia = 32'h1000_0001; ib = 32'h2000_0002; ici = 1'b0; isub = 1'b0;
      iv = 1'b1;
      tick();
      iv = 1'b0;
      n = 0;
      while (!ov && n < 50) begin
         tick();
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            ia = 32'hDEAD_BEEF; ib = 32'h1234_5678; iv = 1'b1;
         end else begin
            iv = 1'b0;
         end
         tick();
         n_chk++;
         if ({ov, ir, co, ovf, res} !== {4'b1000, 32'h3000_0003}) begin
            n_fail++;
            $display("FAIL hold_%0d got=%b_%h want=1000_30000003",
                     i, {ov, ir, co, ovf}, res);
         end
      end
      iv = 1'b0;
      ordy = 1'b1;
      tick();
      ordy = 1'b0;
      n_chk++;
      if ({ov, ir} !== 2'b01) begin
         n_fail++;
         $display("FAIL release got=%b want=01", {ov, ir});
      end
      op32(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, r, cr, of, lat);
      n_chk++;
      if ({of, cr, r} !== {2'b00, 32'h1010_1011} || lat != 4) begin
         n_fail++;
         $display("FAIL after_bp got=%b%b_%h lat=%0d want=00_10101011 lat=4",
                  of, cr, r, lat);
      end
   endtask

   task automatic test_reset_midrun();
      logic [31:0] r;
      logic cr, of;
      int lat, seen;
      ia = 32'hAAAA_AAAA; ib = 32'h5555_5555; ici = 1'b1; isub = 1'b0;
      iv = 1'b1;
      tick();
      iv = 1'b0;
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      n_chk++;
      if ({ir, ov, co, ovf, res} !== 36'h0) begin
         n_fail++;
         $display("FAIL midrun_reset got=%h want=0", {ir, ov, co, ovf, res});
      end
      tick();
      reset = 1'b0;
      n_chk++;
      if (ir !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_ready_low got=%b want=0", ir);
      end
      tick();
      n_chk++;
      if (ir !== 1'b1) begin
         n_fail++;
         $display("FAIL midrun_ready_high got=%b want=1", ir);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (ov) seen++;
         tick();
      end
      n_chk++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL partial_presented got=%0d want=0", seen);
      end
      op32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, r, cr, of, lat);
      n_chk++;
      if ({of, cr, r} !== {2'b00, 32'h2345_6789} || lat != 4) begin
         n_fail++;
         $display("FAIL post_reset_op got=%b%b_%h lat=%0d want=00_23456789 lat=4",
                  of, cr, r, lat);
      end
   endtask

   task automatic test_w4();
      int n, lat;
      n = 0;
      while (!ir4 && n < 20) begin
         tick();
         n++;
      end
      a4 = 4'hF; b4 = 4'h1; ci4 = 1'b1; sub4 = 1'b0;
      iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      lat = 0;
      while (!ov4 && lat < 20) begin
         tick();
         lat++;
      end
      n_chk++;
      if ({ovf4, co4, res4} !== 6'b01_0001 || lat != 4) begin
         n_fail++;
         $display("FAIL w4_op got=%b%b_%h lat=%0d want=01_1 lat=4",
                  ovf4, co4, res4, lat);
      end
      ordy4 = 1'b1;
      tick();
      ordy4 = 1'b0;
   endtask

   task automatic test_w8_back_to_back();
      logic [7:0] va[3], vb[3];
      logic       vc[3], vs[3];
      logic [9:0] ve[3];
      int acc[3];
      int n;
      va[0] = 8'h7F; vb[0] = 8'h01; vc[0] = 1'b0; vs[0] = 1'b0; ve[0] = 10'h280;
      va[1] = 8'h00; vb[1] = 8'h01; vc[1] = 1'b0; vs[1] = 1'b1; ve[1] = 10'h0FF;
      va[2] = 8'hFF; vb[2] = 8'hFF; vc[2] = 1'b1; vs[2] = 1'b0; ve[2] = 10'h1FF;
      ordy8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a8 = va[i]; b8 = vb[i]; ci8 = vc[i]; sub8 = vs[i];
         iv8 = 1'b1;
         n = 0;
         while (!ir8 && n < 20) begin
            tick();
            n++;
         end
         tick();
         acc[i] = cyc;
         iv8 = 1'b0;
         tick();
         n_chk++;
         if (ov8 !== 1'b1 || {ovf8, co8, res8} !== ve[i]) begin
            n_fail++;
            $display("FAIL w8_op%0d got=%b_%h want=1_%h",
                     i, ov8, {ovf8, co8, res8}, ve[i]);
         end
      end
      tick();
      ordy8 = 1'b0;
      n_chk++;
      if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
         n_fail++;
         $display("FAIL w8_interval got=%0d,%0d want=3,3",
                  acc[1] - acc[0], acc[2] - acc[1]);
      end
   endtask

   task automatic test_random();
      logic [33:0] expq[$];
      logic [33:0] e;
      logic [31:0] bb;
      logic [32:0] s;
      logic        of, need;
      int sent, got, bad, td, tm;
      sent = 0; got = 0; bad = 0; td = 0; tm = 0; need = 1'b1;
      fork
         begin
            while (sent < 1000 && td < 40000) begin
               if (need) begin
                  ia = $urandom; ib = $urandom;
                  ici = 1'($urandom_range(0, 1));
                  isub = 1'($urandom_range(0, 1));
                  need = 1'b0;
               end
               iv = ($urandom_range(0, 3) != 0);
               if (iv && ir) begin
                  bb = isub ? ~ib : ib;
                  s = {1'b0, ia} + {1'b0, bb} + {32'h0, (isub | ici)};
                  of = (ia[31] == bb[31]) && (s[31] != ia[31]);
                  expq.push_back({of, s});
                  sent++;
                  need = 1'b1;
               end
               tick();
               td++;
            end
            iv = 1'b0;
         end
         begin
            while (got < 1000 && tm < 40000) begin
               ordy = ($urandom_range(0, 3) != 0);
               if (ov && ordy) begin
                  n_chk++;
                  if (expq.size() == 0) begin
                     n_fail++;
                     $display("FAIL rand_extra got=%h", res);
                  end else begin
                     e = expq.pop_front();
                     if ({ovf, co, res} !== e) begin
                        n_fail++;
                        bad++;
                        if (bad < 10)
                           $display("FAIL rand_%0d got=%h want=%h",
                                    got, {ovf, co, res}, e);
                     end
                  end
                  got++;
               end
               tick();
               tm++;
            end
            ordy = 1'b0;
         end
      join
      n_chk++;
      if (sent != 1000 || got != 1000 || expq.size() != 0) begin
         n_fail++;
         $display("FAIL rand_count sent=%0d got=%0d left=%0d want=1000,1000,0",
                  sent, got, expq.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      iv = 1'b0; ia = '0; ib = '0; ici = 1'b0; isub = 1'b0; ordy = 1'b0;
      iv4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0; sub4 = 1'b0; ordy4 = 1'b0;
      iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0; ordy8 = 1'b0;
      test_reset();
      test_add_wrap();
      test_overflow();
      test_backpressure();
      test_reset_midrun();
      test_w4();
      test_w8_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_chunked.md
# adder_chunked

Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, keeping the ripple carry in a register between chunks. Operands enter through a valid/ready handshake and the result leaves through one. It is the sequential, width-generic replacement for fixed-width ripple adders built from addbit instances, for datapaths where area matters more than latency.

## Interface
- WIDTH, 32, operand/result width; must be a positive multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; NCHUNK = WIDTH/CHUNK (derived localparam).
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- ci  input  1  carry input (add mode only).
- sub  input  1  0: a+b+ci; 1: a-b (ci ignored).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference.
- carry  output  1  carry out; in sub mode 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, in_valid & in_ready (accept):
  - capture a into the operand register;
  - capture sub ? ~b : b into the b register;
  - load the carry register with sub ? 1 : ci;
  - chunk counter = 0; go to RUN.
- RUN, each cycle:
  - chunk i = counter; result[i*CHUNK +: CHUNK] = a_chunk + b_chunk + carry;
  - carry register = chunk carry out;
  - counter increments; at the last chunk (counter == NCHUNK-1) go to DONE.
- DONE:
  - out_valid = 1; result, carry and overflow are held stable;
  - on out_ready go to IDLE.
- overflow is computed during the last chunk as (a_msb == b'_msb) & (sum_msb != a_msb), where b' is the stored, possibly inverted, b.
- in_ready is a registered output equal to 1 exactly when the state is IDLE:
  - reset value 0;
  - rises on the first clock edge after reset deasserts;
  - rises on the DONE→IDLE edge.
- in_valid is ignored outside IDLE. There is no input buffering and no result bypass.
- Reset, including mid-RUN or in DONE, immediately forces:
  - state IDLE, counter 0, carry register 0;
  - out_valid 0, in_ready 0, result 0, carry 0, overflow 0.
  - A partial result is discarded and never presented.
- Arithmetic is modulo 2^WIDTH. The counter is ceil(log2(NCHUNK)) bits, minimum 1.
- The counter never wraps: the RUN exit happens at NCHUNK-1.

## Timing
- Accept at edge k. out_valid is high after edge k+NCHUNK (NCHUNK=1: one cycle).
- With out_ready held high:
  - the result handshake completes at edge k+NCHUNK+1;
  - in_ready is high after that edge;
  - the next accept is at edge k+NCHUNK+2 at the earliest.
- Minimum initiation interval: NCHUNK+2 cycles.
- out_valid stays high until out_ready is sampled high, with no upper bound.
- result, carry and overflow are registered outputs.
- Critical path: one CHUNK-bit adder plus the chunk mux.

## Structure
- No shared package. Keep WIDTH and CHUNK as module parameters and the state encoding as localparams inside the module.
- One sub-module, add_chunk: a combinational CHUNK-bit adder with ports a, b, ci, sum, co, and an additional c_msb (carry into the MSB) for optional overflow cross-check.
  - It is instantiated once and time-multiplexed across chunks.
- Elaboration check: flag a configuration error if WIDTH % CHUNK != 0.

## Test plan
- WIDTH=32, CHUNK=8, a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0 → result 0x00000000, carry 1, overflow 0; out_valid exactly 4 cycles after accept.
- a=0x7FFFFFFF, b=1, add → result 0x80000000, carry 0, overflow 1. Then sub with a=0x80000000, b=1 → 0x7FFFFFFF, carry 1, overflow 1. Then sub with a=5, b=7 → 0xFFFFFFFE, carry 0, overflow 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, outputs stable, in_ready 0, and a pulsed in_valid is ignored. Release → IDLE, then the next operation is correct.
- Assert reset after 2 chunks of RUN → all outputs 0 immediately, no out_valid. in_ready goes to 1 one edge after release. A following a=0x12345678, b=0x11111111 → 0x23456789.
- WIDTH=4, CHUNK=1: a=0xF, b=0x1, ci=1 → result 0x1, carry 1, latency 4. Also WIDTH=CHUNK=8 (latency 1) with back-to-back operations at the NCHUNK+2 interval.
- Random stream of 1000 operations with random in_valid/out_ready stalls, compared against a reference model of {carry, result} = a + b + ci (or a + ~b + 1) plus the overflow rule → zero mismatches, no lost or duplicated results.
